// File: rtl/fmap_bram_pkg.sv
// Shared types and helpers for the feature-map BRAM arbiter.
//   op_e      : operation carried through the completion stage
//   stage_t   : contents of the one-deep issue/completion pipeline register
//   sat_res_t : saturating add result (clamped sum + clamp flag)
//   sat_add   : signed add at FMAP_DW+1 bits, clamped back to FMAP_DW
// The widths here are the arbiter's default DATA_WIDTH/ADDR_WIDTH.
package fmap_bram_pkg;

    localparam int FMAP_DW = 16;
    localparam int FMAP_AW = 10;

    typedef enum logic {
        OP_ACC = 1'b0,
        OP_RD  = 1'b1
    } op_e;

    typedef struct packed {
        logic               valid;
        op_e                op;
        logic [FMAP_AW-1:0] addr;
        logic [FMAP_DW-1:0] delta;
        logic               clear;
        logic               fwd;
        logic [FMAP_DW-1:0] fwd_data;
    } stage_t;

    typedef struct packed {
        logic               sat;
        logic [FMAP_DW-1:0] sum;
    } sat_res_t;

    function automatic sat_res_t sat_add(input logic [FMAP_DW-1:0] a,
                                         input logic [FMAP_DW-1:0] b);
        logic [FMAP_DW:0] full;
        sat_res_t         r;
        full  = {a[FMAP_DW-1], a} + {b[FMAP_DW-1], b};
        // The two top bits disagree exactly when the result left the DW range.
        r.sat = full[FMAP_DW] ^ full[FMAP_DW-1];
        if (!r.sat)
            r.sum = full[FMAP_DW-1:0];
        else if (full[FMAP_DW])
            r.sum = {1'b1, {(FMAP_DW-1){1'b0}}};
        else
            r.sum = {1'b0, {(FMAP_DW-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/fmap_bram_arbiter_rr.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request vector (bit 0 = accumulate, bit 1 = readout)
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
// The pointer names the requester preferred on contention; it resets to
// requester 0 and after every grant moves to the one not just served.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt[ptr] = 1'b1;
        else
            gnt = req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (|gnt)
            ptr <= gnt[0];
    end

endmodule

// File: rtl/fmap_bram_arbiter.sv
// Feature-map BRAM arbiter: serves a saturating accumulate client and a
// readout client (optional clear-on-read) over a dual-port BRAM.
//   acc_*          : accumulate request (addr, signed delta), ready = granted
//   rd_*           : readout request (addr, clear), ready = granted
//   rd_rsp_*       : readout response, fixed 2 cycles after rd_ready
//   sat_pulse      : accumulate clamped (2 cycles after acc_ready)
//   busy           : completion stage occupied
//   bram_*_a       : read-only port, data returns one cycle after en_a
//   bram_*_b       : write-only port, driven in the completion cycle
// Issue reads on A; the next cycle completes the op and writes on B. A write
// completing in the same cycle as a read of the same address is forwarded
// into the stage, so BRAM read-during-write behaviour never matters.
module fmap_bram_arbiter
    import fmap_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0] acc_delta,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clear,
    output logic                  rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  sat_pulse,
    output logic                  busy,
    output logic                  bram_clk,
    output logic                  bram_rst_n,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [DATA_WIDTH-1:0] bram_data_in_a,
    output logic                  bram_we_a,
    output logic                  bram_en_a,
    input  logic [DATA_WIDTH-1:0] bram_data_out_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_data_in_b,
    output logic                  bram_we_b,
    output logic                  bram_en_b,
    input  logic [DATA_WIDTH-1:0] bram_data_out_b
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] issue_addr;
    stage_t                stage_q;
    stage_t                stage_d;
    logic [DATA_WIDTH-1:0] src_data;
    sat_res_t              sres;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  unused_data_out_b;

    assign unused_data_out_b = ^bram_data_out_b;

    // Gating with rst_n keeps both readies low for the whole reset.
    assign req = {rd_valid & rst_n, acc_valid & rst_n};

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign acc_ready  = gnt[0];
    assign rd_ready   = gnt[1];
    assign issue_addr = gnt[0] ? acc_addr : rd_addr;

    assign bram_clk       = clk;
    assign bram_rst_n     = rst_n;
    assign bram_en_a      = |gnt;
    assign bram_addr_a    = issue_addr;
    assign bram_we_a      = 1'b0;
    assign bram_data_in_a = '0;

    // Completion of the op issued last cycle.
    assign src_data = stage_q.fwd ? stage_q.fwd_data : bram_data_out_a;
    assign sres     = sat_add(src_data, stage_q.delta);
    assign wr_en    = stage_q.valid && (stage_q.op == OP_ACC || stage_q.clear);
    assign wr_data  = (stage_q.op == OP_ACC) ? sres.sum : '0;

    assign bram_en_b      = wr_en;
    assign bram_we_b      = wr_en;
    assign bram_addr_b    = stage_q.addr;
    assign bram_data_in_b = wr_data;

    always_comb begin
        stage_d = '0;
        if (|gnt) begin
            stage_d.valid    = 1'b1;
            stage_d.op       = gnt[0] ? OP_ACC : OP_RD;
            stage_d.addr     = issue_addr;
            stage_d.delta    = gnt[0] ? acc_delta : '0;
            stage_d.clear    = gnt[1] & rd_clear;
            stage_d.fwd      = wr_en && (stage_q.addr == issue_addr);
            stage_d.fwd_data = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
            sat_pulse    <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            rd_rsp_valid <= stage_q.valid && (stage_q.op == OP_RD);
            rd_rsp_data  <= (stage_q.valid && stage_q.op == OP_RD) ? src_data : '0;
            sat_pulse    <= stage_q.valid && (stage_q.op == OP_ACC) && sres.sat;
        end
    end

    assign busy = stage_q.valid;

endmodule

// File: doc/fmap_bram_arbiter.md
Name: fmap_bram_arbiter

Overview:
- Arbiter end of the dual-port feature-map BRAM protocol. It drives both BRAM ports (clk, rst_n, addr/din/we/en for A and B) and consumes both data outputs.
- It serves two clients:
  - Convolution accumulate client: read-modify-write of saturating signed sums.
  - Readout client: read, with optional clear-on-read.
- Port A is dedicated to reads and port B to writes. Hazards are handled by a one-stage pipeline with forwarding.
- Sits between the conv engine/readout FSM and the BRAM module.

Parameters:
- DATA_WIDTH, 16, signed feature-map word width
- ADDR_WIDTH, 10, BRAM address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- acc_valid  in  1  accumulate request valid
- acc_ready  out  1  accumulate request accepted this cycle
- acc_addr  in  ADDR_WIDTH  accumulate target address
- acc_delta  in  DATA_WIDTH  signed value added to stored word
- rd_valid  in  1  readout request valid
- rd_ready  out  1  readout request accepted this cycle
- rd_addr  in  ADDR_WIDTH  readout address
- rd_clear  in  1  write zero after read
- rd_rsp_valid  out  1  readout response valid (no backpressure)
- rd_rsp_data  out  DATA_WIDTH  readout data
- sat_pulse  out  1  one-cycle pulse when an accumulate saturated
- busy  out  1  pipeline stage occupied
- bram_clk  out  1  equals clk
- bram_rst_n  out  1  equals rst_n
- bram_addr_a / bram_data_in_a / bram_we_a / bram_en_a  out  AW/DW/1/1  port A (read only; we_a=0, data_in_a=0 always)
- bram_data_out_a  in  DATA_WIDTH  port A read data, valid one cycle after en_a
- bram_addr_b / bram_data_in_b / bram_we_b / bram_en_b  out  AW/DW/1/1  port B (write only)
- bram_data_out_b  in  DATA_WIDTH  unused

Behaviour:
- Reset: all registered outputs are 0, the pipeline stage is invalid, and the round-robin pointer points at the accumulate client. While rst_n=0, acc_ready=rd_ready=0.
- Reset mid-operation drops the in-flight op: no write is issued and no response is given.
- Arbitration is combinational, at most one grant per cycle:
  - Only one client valid: that client is granted.
  - Both valid: the client not granted last time is granted. The pointer updates on every grant.
- Issue (cycle t), on grant:
  - bram_en_a=1 and bram_addr_a = granted address.
  - Stage register captures op (ACC/RD), addr, delta, clear.
  - Ready is high only in the grant cycle.
- Completion (cycle t+1):
  - Source word = forwarded value if the forward flag is set, else bram_data_out_a.
  - ACC: sum = source + delta, computed at DATA_WIDTH+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
    - Write sum on port B: en_b=we_b=1, addr_b=stage addr.
    - sat_pulse=1 at t+2 (registered) if clamped.
  - RD: rd_rsp_valid=1 and rd_rsp_data=source, registered, so visible at t+2 (fixed latency 2 from accept).
    - If clear: write 0 on port B in cycle t+1.
- Forwarding:
  - If the issue at cycle t+1 targets the same address as a completing op that writes (ACC, or RD with clear), the written value is captured and flagged.
  - The next completion uses that value instead of bram_data_out_a.
  - BRAM read-during-write behaviour is therefore irrelevant.
  - RD without clear never forwards.
- Throughput is one op per cycle sustained. Port B writes never stall issue.
- busy=1 whenever the stage is valid.
- Port A and port B never write the same cycle to the same address (port A never writes).

Decomposition:
- Shared package fmap_bram_pkg holds:
  - op_e enum {OP_ACC, OP_RD}
  - stage_t struct {valid, op, addr, delta, clear, fwd, fwd_data}
  - a sat_add function parameterised by width via localparams matching the defaults
- One sub-module is natural: rr_arbiter2 (2-requester round-robin, grant + pointer register).

Test Plan:
- Single ACC at addr 5, BRAM word 100, delta 23 → acc_ready pulse; port B writes 123 to addr 5 one cycle later; sat_pulse=0.
- ACC addr 7, word 32760, delta 20 → write 32767 and sat_pulse=1. ACC with word -32760, delta -20 → write -32768.
- Back-to-back ACC to addr 3 (start 0, deltas 1,2,3 on consecutive cycles) → writes 1, 3, 6. The final word is 6, which shows forwarding.
- Both clients valid for 4 cycles → grants alternate ACC, RD, ACC, RD. The RD response arrives 2 cycles after each rd_ready.
- RD addr 9 with clear (word 55) → rd_rsp_data=55 and port B writes 0 to addr 9. A following ACC delta 4 to addr 9 → writes 4.
- Assert rst_n=0 the cycle after an ACC grant → no port B write; all outputs 0; after release, a fresh ACC completes normally.
